cmt_prover: RTL and testbench
=============================

CMT_PROVER -- requirements
Module: cmt_prover

Interface
REQ-001 Parameters SHALL be: NUM_LAYER 3, layer count below inputs; LN_LAYER 1, layer index MSB; G 3, max gate index; LN_G 1, gate index MSB; NUM_BITS 3, gateSel MSB; INT_WIDTH 31, data MSB.
REQ-002 clk  in  1  clock.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 cfg_we  in  1  wiring-table write strobe.
REQ-005 cfg_layer  in  LN_LAYER+1  layer of configured gate; cfg_gate  in  LN_G+1  gate index.
REQ-006 cfg_isAdd  in  1  gate type, 1 add / 0 mul; cfg_in0, cfg_in1  in  LN_G+1 each  input gate indices in layer cfg_layer+1.
REQ-007 in_we  in  1  input write strobe; in_gate  in  LN_G+1  index; in_data  in  INT_WIDTH+1  value for layer NUM_LAYER.
REQ-008 start  in  1  begin circuit evaluation; busy  out  1  evaluating; ready  out  1  values valid.
REQ-009 currLayer  in  LN_LAYER+1; currGate  in  LN_G+1  gate under verification.
REQ-010 result  out  INT_WIDTH+1  V_currLayer(currGate).
REQ-011 sc_start  in  1  pulse opening a sumcheck for (currLayer, currGate); random  in  1  verifier challenge bit, sampled each cycle.
REQ-012 poly  out  G+1 x (INT_WIDTH+1)  round polynomial coefficients.
REQ-013 gateSel  in  NUM_BITS+1  {hi gate, lo gate}; gateRslt  out  2 x (INT_WIDTH+1)  [1]=V_{currLayer+1}(hi), [0]=V_{currLayer+1}(lo).

Function
REQ-014 Storage SHALL be a value table of (NUM_LAYER+1)x(G+1) words and a wiring table of NUM_LAYER x (G+1) {isAdd, in0, in1} entries.
REQ-015 FSM SHALL have states IDLE, EVAL, READY; busy=1 only in EVAL, ready=1 only in READY.
REQ-016 cfg_we/in_we SHALL write in IDLE or READY; a write in READY SHALL return FSM to IDLE; writes in EVAL SHALL be ignored.
REQ-017 start in IDLE or READY SHALL enter EVAL; start in EVAL SHALL be ignored.
REQ-018 EVAL SHALL compute one gate per cycle, layer NUM_LAYER-1 down to 0, gate 0 to G: V_L(g)=isAdd ? V_{L+1}(in0)+V_{L+1}(in1) : V_{L+1}(in0)*V_{L+1}(in1), truncated to INT_WIDTH+1 bits.
REQ-019 EVAL SHALL last exactly NUM_LAYER*(G+1) cycles (12 default), then enter READY.
REQ-020 result and gateRslt SHALL be combinational table reads, valid whenever ready=1; gateRslt SHALL read 0 when currLayer=NUM_LAYER.
REQ-021 Sumcheck tracker: sc_start SHALL clear prefix and set round=0, active=1; each subsequent cycle with active=1 SHALL latch random into prefix[round] and increment round; after round NUM_BITS latches, active SHALL clear.
REQ-022 sc_start while active SHALL restart the tracker; sc_start with ready=0 SHALL be ignored.
REQ-023 Candidate set S SHALL be {conn={in1,in0}, swap={in0,in1}} of wiring(currLayer,currGate), deduplicated when in0==in1.
REQ-024 For round k, v_b SHALL be the sum over z in S with z[k-1:0]==prefix[k-1:0] and z[k]==b of op(V_{currLayer+1}(z hi), V_{currLayer+1}(z lo)), op per isAdd.
REQ-025 poly[0] SHALL be v_0, poly[1] SHALL be v_1-v_0 mod 2^(INT_WIDTH+1), poly[2..G] SHALL be 0.
REQ-026 poly SHALL be all-zero when active=0, ready=0, or currLayer=NUM_LAYER.

Reset
REQ-027 nrst low SHALL force IDLE, busy=0, ready=0, active=0, round=0, prefix=0 immediately; tables SHALL be unaffected.
REQ-028 Reset during EVAL SHALL abort; ready SHALL stay 0 until next complete EVAL.

Verification
REQ-029 Load inputs [1,2,3,4]; layer2 g0 add(0,1), g1 mul(2,3), g2 add(1,2), g3 mul(0,3); layer1 g0 mul(0,1), g1 add(2,3), g2 add(0,0), g3 mul(1,1); layer0 g0 add(0,1), g1-g3 add(2,3); start -> busy 12 cycles, then ready; V2=[3,12,5,4], V1=[36,9,6,144], V0=[45,150,150,150].
REQ-030 currLayer=0, currGate=0, sc_start, round0 -> poly[0]=45, poly[1]=0; random=1 then round1 -> poly[0]=45, poly[1]=0xFFFFFFD3.
REQ-031 currLayer=0, gateSel=4'b0001 -> gateRslt[1]=36, gateRslt[0]=9.
REQ-032 currLayer=1, currGate=2 (in0==in1=0), round0 -> poly[0]=6, poly[1]=0xFFFFFFFA (single candidate).
REQ-033 in_we in READY -> ready=0 next cycle, poly=0; start during EVAL ignored, EVAL length unchanged.
REQ-034 nrst asserted at EVAL cycle 5 -> busy=0, ready=0 immediately; new start -> ready after 12 cycles with REQ-029 values.

Source files
------------

// File: rtl/cmt_prover.sv
// Layered arithmetic-circuit evaluator with a sumcheck-style round-polynomial helper.
// Circuit values are computed layer by layer from the inputs, one gate per cycle.
module cmt_prover #(
  parameter int unsigned NUM_LAYER = 3,
  parameter int unsigned LN_LAYER  = 1,
  parameter int unsigned G         = 3,
  parameter int unsigned LN_G      = 1,
  parameter int unsigned NUM_BITS  = 3,
  parameter int unsigned INT_WIDTH = 31
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          cfg_we,
  input  logic [LN_LAYER:0]             cfg_layer,
  input  logic [LN_G:0]                 cfg_gate,
  input  logic                          cfg_isAdd,
  input  logic [LN_G:0]                 cfg_in0,
  input  logic [LN_G:0]                 cfg_in1,
  input  logic                          in_we,
  input  logic [LN_G:0]                 in_gate,
  input  logic [INT_WIDTH:0]            in_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          ready,
  input  logic [LN_LAYER:0]             currLayer,
  input  logic [LN_G:0]                 currGate,
  output logic [INT_WIDTH:0]            result,
  input  logic                          sc_start,
  input  logic                          random,
  output logic [G:0][INT_WIDTH:0]       poly,
  input  logic [NUM_BITS:0]             gateSel,
  output logic [1:0][INT_WIDTH:0]       gateRslt
);

  localparam int unsigned RW = $clog2(NUM_BITS + 2);
  localparam logic [LN_LAYER:0] LastLayer = (LN_LAYER + 1)'(NUM_LAYER);
  localparam logic [LN_LAYER:0] LayerOne  = (LN_LAYER + 1)'(1);
  localparam logic [LN_G:0]     LastGate  = (LN_G + 1)'(G);
  localparam logic [LN_G:0]     GateOne   = (LN_G + 1)'(1);
  localparam logic [RW-1:0]     LastRound = RW'(NUM_BITS);
  localparam logic [RW-1:0]     RoundOne  = RW'(1);
  localparam logic [NUM_BITS:0] AllOnes   = '1;

  typedef enum logic [1:0] {StIdle, StEval, StReady} state_e;

  state_e state_q, state_d;

  // Value table: layer NUM_LAYER holds the circuit inputs.
  logic [INT_WIDTH:0] vals  [NUM_LAYER+1][G+1];
  logic               w_add [NUM_LAYER][G+1];
  logic [LN_G:0]      w_in0 [NUM_LAYER][G+1];
  logic [LN_G:0]      w_in1 [NUM_LAYER][G+1];

  logic [LN_LAYER:0]  ev_layer_q, ev_src;
  logic [LN_G:0]      ev_gate_q;
  logic [INT_WIDTH:0] ev_a, ev_b, ev_val;
  logic               ev_last;

  logic               active_q;
  logic [RW-1:0]      round_q;
  logic [NUM_BITS:0]  prefix_q;

  logic                   wr_ok;
  logic [LN_LAYER:0]      sc_layer, src_layer;
  logic [LN_G:0]          sc_in0, sc_in1;
  logic [INT_WIDTH:0]     opa, opb, sc_val, v0, v1;
  logic [1:0][NUM_BITS:0] cand;
  logic [1:0]             cand_ok;
  logic [NUM_BITS:0]      low_mask;

  assign wr_ok = (state_q != StEval);

  // FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StEval;
      end
      StEval: begin
        busy = 1'b1;
        if (ev_last) state_d = StReady;
      end
      StReady: begin
        ready = 1'b1;
        if (start)                state_d = StEval;
        else if (cfg_we || in_we) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Evaluation walks layers top-down, gates 0..G within each layer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ev_layer_q <= '0;
      ev_gate_q  <= '0;
    end else if (start && state_q != StEval) begin
      ev_layer_q <= LastLayer - LayerOne;
      ev_gate_q  <= '0;
    end else if (state_q == StEval) begin
      if (ev_gate_q == LastGate) begin
        ev_gate_q  <= '0;
        ev_layer_q <= ev_layer_q - LayerOne;
      end else begin
        ev_gate_q <= ev_gate_q + GateOne;
      end
    end
  end

  assign ev_last = (ev_layer_q == '0) && (ev_gate_q == LastGate);
  assign ev_src  = ev_layer_q + LayerOne;

  always_comb begin
    ev_a   = vals[ev_src][w_in0[ev_layer_q][ev_gate_q]];
    ev_b   = vals[ev_src][w_in1[ev_layer_q][ev_gate_q]];
    ev_val = w_add[ev_layer_q][ev_gate_q] ? ev_a + ev_b : ev_a * ev_b;
  end

  // Tables carry no reset so a reset never wipes a loaded circuit.
  always_ff @(posedge clk) begin
    if (state_q == StEval) begin
      vals[ev_layer_q][ev_gate_q] <= ev_val;
    end else if (in_we) begin
      vals[LastLayer][in_gate] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && cfg_we && cfg_layer < LastLayer) begin
      w_add[cfg_layer][cfg_gate] <= cfg_isAdd;
      w_in0[cfg_layer][cfg_gate] <= cfg_in0;
      w_in1[cfg_layer][cfg_gate] <= cfg_in1;
    end
  end

  // Sumcheck round tracker; prefix is cleared on open so bits can be OR-ed in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active_q <= 1'b0;
      round_q  <= '0;
      prefix_q <= '0;
    end else if (sc_start && ready) begin
      active_q <= 1'b1;
      round_q  <= '0;
      prefix_q <= '0;
    end else if (active_q) begin
      prefix_q <= prefix_q | ((NUM_BITS + 1)'(random) << round_q);
      round_q  <= round_q + RoundOne;
      if (round_q == LastRound) active_q <= 1'b0;
    end
  end

  assign result = vals[currLayer][currGate];

  always_comb begin
    sc_layer   = (currLayer < LastLayer) ? currLayer : '0;
    src_layer  = currLayer + LayerOne;
    sc_in0     = w_in0[sc_layer][currGate];
    sc_in1     = w_in1[sc_layer][currGate];
    opa        = vals[src_layer][sc_in0];
    opb        = vals[src_layer][sc_in1];
    sc_val     = w_add[sc_layer][currGate] ? opa + opb : opa * opb;
    cand[0]    = {sc_in1, sc_in0};
    cand[1]    = {sc_in0, sc_in1};
    cand_ok[0] = 1'b1;
    cand_ok[1] = (sc_in0 != sc_in1);
    low_mask   = ~(AllOnes << round_q);
    v0         = '0;
    v1         = '0;
    for (int i = 0; i < 2; i++) begin
      if (cand_ok[i] && ((cand[i] ^ prefix_q) & low_mask) == '0) begin
        if (1'(cand[i] >> round_q)) v1 = v1 + sc_val;
        else                        v0 = v0 + sc_val;
      end
    end
    poly = '0;
    if (active_q && state_q == StReady && currLayer < LastLayer) begin
      poly[0] = v0;
      poly[1] = v1 - v0;
    end
  end

  always_comb begin
    gateRslt = '0;
    if (currLayer < LastLayer) begin
      gateRslt[1] = vals[src_layer][gateSel[NUM_BITS:LN_G+1]];
      gateRslt[0] = vals[src_layer][gateSel[LN_G:0]];
    end
  end

endmodule

// File: tb/tb_cmt_prover.sv
// Self-checking bench for cmt_prover: fixed reference circuit plus randomized circuits
// checked against a behavioural model of circuit values and round polynomials.
module tb_cmt_prover;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              cfg_we = 1'b0, cfg_isAdd = 1'b0;
  logic [1:0]        cfg_layer = '0, cfg_gate = '0, cfg_in0 = '0, cfg_in1 = '0;
  logic              in_we = 1'b0;
  logic [1:0]        in_gate = '0;
  logic [31:0]       in_data = '0;
  logic              start = 1'b0, busy, ready;
  logic [1:0]        currLayer = '0, currGate = '0;
  logic [31:0]       result;
  logic              sc_start = 1'b0, random = 1'b0;
  logic [3:0][31:0]  poly;
  logic [3:0]        gateSel = '0;
  logic [1:0][31:0]  gateRslt;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  logic [31:0] mv [0:3][0:3];
  int m_add [0:2][0:3];
  int m_in0 [0:2][0:3];
  int m_in1 [0:2][0:3];

  // Reference circuit, row = layer
  int ref_add [0:2][0:3] = '{'{1, 1, 1, 1}, '{0, 1, 1, 0}, '{1, 0, 1, 0}};
  int ref_in0 [0:2][0:3] = '{'{0, 2, 2, 2}, '{0, 2, 0, 1}, '{0, 2, 1, 0}};
  int ref_in1 [0:2][0:3] = '{'{1, 3, 3, 3}, '{1, 3, 0, 1}, '{1, 3, 2, 3}};
  int ref_val [0:3][0:3] = '{'{45, 150, 150, 150}, '{36, 9, 6, 144}, '{3, 12, 5, 4},
                             '{1, 2, 3, 4}};

  always #5 clk = ~clk;

  cmt_prover dut (
    .clk(clk), .nrst(nrst), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_gate(cfg_gate),
    .cfg_isAdd(cfg_isAdd), .cfg_in0(cfg_in0), .cfg_in1(cfg_in1), .in_we(in_we),
    .in_gate(in_gate), .in_data(in_data), .start(start), .busy(busy), .ready(ready),
    .currLayer(currLayer), .currGate(currGate), .result(result), .sc_start(sc_start),
    .random(random), .poly(poly), .gateSel(gateSel), .gateRslt(gateRslt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int l, input int g, input int a, input int i0, input int i1);
    cfg_layer = 2'(l); cfg_gate = 2'(g); cfg_isAdd = 1'(a);
    cfg_in0 = 2'(i0); cfg_in1 = 2'(i1); cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    m_add[l][g] = a; m_in0[l][g] = i0; m_in1[l][g] = i1;
  endtask

  task automatic do_in(input int g, input logic [31:0] d);
    in_gate = 2'(g); in_data = d; in_we = 1'b1;
    tick();
    in_we = 1'b0;
    mv[3][g] = d;
  endtask

  function automatic logic [31:0] op(input int a, input logic [31:0] x, input logic [31:0] y);
    return (a != 0) ? x + y : x * y;
  endfunction

  function automatic void model_eval();
    for (int l = 2; l >= 0; l--)
      for (int g = 0; g < 4; g++)
        mv[l][g] = op(m_add[l][g], mv[l+1][m_in0[l][g]], mv[l+1][m_in1[l][g]]);
  endfunction

  // Sum of gate values over candidate wirings z matching the prefix with z[k]==b.
  function automatic logic [31:0] model_v(input int l, input int g, input int k,
                                          input int pre, input int b);
    int zs[$];
    logic [31:0] sum = 0;
    int i0 = m_in0[l][g];
    int i1 = m_in1[l][g];
    zs.push_back(i1 * 4 + i0);
    if (i0 != i1) zs.push_back(i0 * 4 + i1);
    foreach (zs[n]) begin
      int z = zs[n];
      if ((z % (1 << k)) == (pre % (1 << k)) && ((z >> k) & 1) == b)
        sum = sum + op(m_add[l][g], mv[l+1][z / 4], mv[l+1][z % 4]);
    end
    return sum;
  endfunction

  task automatic run_eval(output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b ready=%b, required 0/0", busy, ready);
    end
    n_chk++;
    if (poly !== '0) begin
      n_fail++;
      $display("FAIL reset_poly: poly=%h, required 0", poly);
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_ref_circuit();
    int cyc;
    for (int g = 0; g < 4; g++) do_in(g, 32'(g + 1));
    for (int l = 0; l < 3; l++)
      for (int g = 0; g < 4; g++)
        do_cfg(l, g, ref_add[l][g], ref_in0[l][g], ref_in1[l][g]);
    model_eval();
    run_eval(cyc);
    n_chk++;
    if (cyc != 12 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ref_eval_len: cycles=%0d ready=%b, required 12/1", cyc, ready);
    end
    for (int l = 0; l < 4; l++)
      for (int g = 0; g < 4; g++) begin
        currLayer = 2'(l); currGate = 2'(g);
        #1;
        n_chk++;
        if (result !== 32'(ref_val[l][g])) begin
          n_fail++;
          $display("FAIL ref_value L%0d g%0d: got %0d, required %0d", l, g, result,
                   ref_val[l][g]);
        end
      end
  endtask

  task automatic test_spec_sumcheck();
    currLayer = 2'd0; currGate = 2'd0; random = 1'b0;
    sc_start = 1'b1; tick(); sc_start = 1'b0;
    n_chk++;
    if (poly[0] !== 32'd45 || poly[1] !== 32'd0 || poly[2] !== 0 || poly[3] !== 0) begin
      n_fail++;
      $display("FAIL sc_l0g0_r0: poly=%h, required 0/0/0/45", poly);
    end
    random = 1'b1; tick(); random = 1'b0;
    n_chk++;
    if (poly[0] !== 32'd45 || poly[1] !== 32'hFFFFFFD3) begin
      n_fail++;
      $display("FAIL sc_l0g0_r1: p0=%h p1=%h, required 2d/ffffffd3", poly[0], poly[1]);
    end
    currLayer = 2'd1; currGate = 2'd2;
    sc_start = 1'b1; tick(); sc_start = 1'b0;
    n_chk++;
    if (poly[0] !== 32'd6 || poly[1] !== 32'hFFFFFFFA) begin
      n_fail++;
      $display("FAIL sc_l1g2_single: p0=%h p1=%h, required 6/fffffffa", poly[0], poly[1]);
    end
    currLayer = 2'd3;
    sc_start = 1'b1; tick(); sc_start = 1'b0;
    n_chk++;
    if (poly !== '0) begin
      n_fail++;
      $display("FAIL sc_input_layer: poly=%h, required 0", poly);
    end
  endtask

  task automatic test_gatesel();
    currLayer = 2'd0; gateSel = 4'b0001;
    #1;
    n_chk++;
    if (gateRslt[1] !== 32'd36 || gateRslt[0] !== 32'd9) begin
      n_fail++;
      $display("FAIL gatesel_l0: got %0d/%0d, required 36/9", gateRslt[1], gateRslt[0]);
    end
    currLayer = 2'd3;
    #1;
    n_chk++;
    if (gateRslt !== '0) begin
      n_fail++;
      $display("FAIL gatesel_inputs: got %h, required 0", gateRslt);
    end
  endtask

  task automatic test_write_in_ready();
    currLayer = 2'd0; currGate = 2'd0;
    sc_start = 1'b1; tick(); sc_start = 1'b0;
    n_chk++;
    if (poly[0] !== 32'd45) begin
      n_fail++;
      $display("FAIL wr_ready_pre: p0=%0d, required 45", poly[0]);
    end
    do_in(0, 32'd1);
    n_chk++;
    if (ready !== 1'b0 || poly !== '0) begin
      n_fail++;
      $display("FAIL wr_ready_drop: ready=%b poly=%h, required 0/0", ready, poly);
    end
  endtask

  task automatic test_start_in_eval();
    int cyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      start = (cyc == 5);
      // Table writes during evaluation must be dropped.
      cfg_we = (cyc == 3); cfg_layer = 2'd0; cfg_gate = 2'd0; cfg_isAdd = 1'b0;
      cfg_in0 = 2'd2; cfg_in1 = 2'd3;
      in_we = (cyc == 4); in_gate = 2'd0; in_data = 32'd99;
      tick();
    end
    start = 1'b0; cfg_we = 1'b0; in_we = 1'b0;
    n_chk++;
    if (cyc != 12 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_eval_len: cycles=%0d ready=%b, required 12/1", cyc, ready);
    end
    currLayer = 2'd0; currGate = 2'd0;
    #1;
    n_chk++;
    if (result !== 32'd45) begin
      n_fail++;
      $display("FAIL cfg_in_eval_ignored: V0(0)=%0d, required 45", result);
    end
    currLayer = 2'd3;
    #1;
    n_chk++;
    if (result !== 32'd1) begin
      n_fail++;
      $display("FAIL in_in_eval_ignored: V3(0)=%0d, required 1", result);
    end
  endtask

  task automatic test_reset_mid_eval();
    int cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    nrst = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: busy=%b ready=%b, required 0/0", busy, ready);
    end
    tick();
    nrst = 1'b1;
    tick();
    n_chk++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: busy=%b ready=%b, required 0/0", busy, ready);
    end
    run_eval(cyc);
    n_chk++;
    if (cyc != 12 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_rerun: cycles=%0d ready=%b, required 12/1", cyc, ready);
    end
    for (int g = 0; g < 4; g++) begin
      currLayer = 2'd0; currGate = 2'(g);
      #1;
      n_chk++;
      if (result !== 32'(ref_val[0][g])) begin
        n_fail++;
        $display("FAIL mid_reset_v0 g%0d: got %0d, required %0d", g, result, ref_val[0][g]);
      end
    end
  endtask

  task automatic test_random();
    int cyc, l, g, pre, r;
    logic [31:0] e0, e1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++)
        do_in(i, (it % 2 == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom));
      for (int li = 0; li < 3; li++)
        for (int gi = 0; gi < 4; gi++)
          do_cfg(li, gi, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      model_eval();
      run_eval(cyc);
      n_chk++;
      if (cyc != 12 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_eval_len it%0d: cycles=%0d ready=%b, required 12/1", it, cyc, ready);
      end
      for (int li = 0; li < 4; li++)
        for (int gi = 0; gi < 4; gi++) begin
          currLayer = 2'(li); currGate = 2'(gi);
          #1;
          n_chk++;
          if (result !== mv[li][gi]) begin
            n_fail++;
            $display("FAIL rnd_value it%0d L%0d g%0d: got %h, required %h", it, li, gi,
                     result, mv[li][gi]);
          end
        end
      l = int'($urandom_range(0, 2));
      gateSel = 4'($urandom_range(0, 15));
      currLayer = 2'(l);
      #1;
      n_chk++;
      if (gateRslt[1] !== mv[l+1][gateSel[3:2]] || gateRslt[0] !== mv[l+1][gateSel[1:0]]) begin
        n_fail++;
        $display("FAIL rnd_gatesel it%0d: got %h/%h, required %h/%h", it, gateRslt[1],
                 gateRslt[0], mv[l+1][gateSel[3:2]], mv[l+1][gateSel[1:0]]);
      end
      g = int'($urandom_range(0, 3));
      currGate = 2'(g);
      pre = 0;
      sc_start = 1'b1; tick(); sc_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        e0 = model_v(l, g, k, pre, 0);
        e1 = model_v(l, g, k, pre, 1) - e0;
        n_chk++;
        if (poly[0] !== e0 || poly[1] !== e1 || poly[2] !== 0 || poly[3] !== 0) begin
          n_fail++;
          $display("FAIL rnd_poly it%0d round%0d: got %h, required p0=%h p1=%h", it, k,
                   poly, e0, e1);
        end
        r = int'($urandom_range(0, 1));
        random = 1'(r);
        pre = pre | (r << k);
        tick();
      end
      random = 1'b0;
      n_chk++;
      if (poly !== '0) begin
        n_fail++;
        $display("FAIL rnd_sc_done it%0d: poly=%h, required 0", it, poly);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ref_circuit();
    test_spec_sumcheck();
    test_gatesel();
    test_write_in_ready();
    test_start_in_eval();
    test_reset_mid_eval();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
